uart_rx_axis: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. Supports configurable data width, parity mode and stop-bit count. Output is an AXI-Stream master with tready backpressure, a one-word holding register and per-word error flags. It sits between the board RXD pin and the byte-stream fabric, for example the command parser or a FIFO.

---
 rtl/uart_rx_axis.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_axis.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// UART receiver with configurable data width, parity and stop bits.
// Received words leave through an AXI-Stream master with a single holding register.
module uart_rx_axis #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  output logic                 o_m_axis_tvalid,
  input  logic                 i_m_axis_tready,
  output logic [DATA_BITS-1:0] o_m_axis_tdata,
  output logic [1:0]           o_m_axis_tuser,
  output logic                 o_rxd_busy,
  output logic                 o_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  logic [1:0]           sync_q;
  logic                 rxs;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 tvalid_q, tvalid_d;
  logic [DATA_BITS-1:0] tdata_q, tdata_d;
  logic [1:0]           tuser_q, tuser_d;
  logic                 overrun_q, overrun_d;
  logic                 bit_tick;
  logic                 frame_done;

  assign rxs = sync_q[1];

  // Synchroniser resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      sync_q <= {sync_q[0], i_rxd};
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first; otherwise a missed branch infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    bit_tick   = (cnt_q == CNT_MAX);

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        stop_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d         = '0;
          data_d[idx_q] = rxs;
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          perr_d  = ((^data_q) ^ rxs) != ODD;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rxs;
          if (stop_q == STOP_LAST) begin
            frame_done = 1'b1;
            state_d    = rxs ? S_IDLE : S_BREAK;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A handshake and a new frame in the same cycle reload the holding register with no bubble.
  always_comb begin
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    overrun_d = 1'b0;
    if (tvalid_q && i_m_axis_tready) tvalid_d = 1'b0;
    if (frame_done) begin
      if (!tvalid_q || i_m_axis_tready) begin
        tvalid_d = 1'b1;
        tdata_d  = data_q;
        tuser_d  = {ferr_d, perr_q};
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      // NOTE: the shift register is a handful of flops, so it is reset for deterministic contents.
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_m_axis_tvalid = tvalid_q;
  assign o_m_axis_tdata  = tdata_q;
  assign o_m_axis_tuser  = tuser_q;
  assign o_overrun       = overrun_q;
  assign o_rxd_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_axis.sv
// Scoreboarded bench for uart_rx_axis: one 8N1 instance and one 7E2 instance,
// both at 16 clocks per bit, driven with directed and random frames.
`timescale 1ns/1ps
module tb_uart_rx_axis;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rxd0 = 1'b1, rxd1 = 1'b1;
  logic       tready0 = 1'b0, tready1 = 1'b0;
  logic       tvalid0, tvalid1, busy0, busy1, ovr0, ovr1;
  logic [7:0] tdata0;
  logic [6:0] tdata1;
  logic [1:0] tuser0, tuser1;

  uart_rx_axis #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd0),
    .o_m_axis_tvalid(tvalid0), .i_m_axis_tready(tready0),
    .o_m_axis_tdata(tdata0), .o_m_axis_tuser(tuser0),
    .o_rxd_busy(busy0), .o_overrun(ovr0)
  );

  uart_rx_axis #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd1),
    .o_m_axis_tvalid(tvalid1), .i_m_axis_tready(tready1),
    .o_m_axis_tdata(tdata1), .o_m_axis_tuser(tuser1),
    .o_rxd_busy(busy1), .o_overrun(ovr1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] data;
    logic [1:0] user;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   vcyc0 = 0, ocnt0 = 0, ocnt1 = 0, ws0 = 0, ws1 = 0;
  bit   pv0 = 0, ph0 = 0, pv1 = 0, ph1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: a word's presentation cycle is recorded when tvalid rises or reloads after a handshake.
  always @(negedge clk) begin
    if (tvalid0 && (!pv0 || ph0)) ws0 = cyc;
    if (tvalid0) vcyc0++;
    if (ovr0) ocnt0++;
    if (tvalid0 && tready0) begin
      check("sb0_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("tdata0", 32'(tdata0), 32'(e0.data));
        check("tuser0", 32'(tuser0), 32'(e0.user));
        if (e0.lat >= 0) check("latency0", ws0, e0.lat);
      end
    end
    pv0 = tvalid0;
    ph0 = tvalid0 && tready0;
  end

  always @(negedge clk) begin
    if (tvalid1 && (!pv1 || ph1)) ws1 = cyc;
    if (ovr1) ocnt1++;
    if (tvalid1 && tready1) begin
      check("sb1_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("tdata1", 32'(tdata1), 32'(e1.data));
        check("tuser1", 32'(tuser1), 32'(e1.user));
        if (e1.lat >= 0) check("latency1", ws1, e1.lat);
      end
    end
    pv1 = tvalid1;
    ph1 = tvalid1 && tready1;
  end

  // Entered just after a clock edge; drives n line bits LSB first, CPB clocks each.
  task automatic send(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rxd0 = bits[i];
      else            rxd1 = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  // Line level to word: 2 synchroniser stages, idle detect, mid-bit offset, L bit periods, output register.
  function automatic int exp_lat(input int c0, input int frame_bits);
    return c0 + 4 + HALF + frame_bits * CPB;
  endfunction

  task automatic frame0(input logic [7:0] d, input bit push, input bit chk_lat);
    exp_t e;
    int   c0;
    @(posedge clk); #1;
    c0 = cyc;
    if (push) begin
      e.data = {1'b0, d};
      e.user = 2'b00;
      e.lat  = chk_lat ? exp_lat(c0, 9) : -1;
      q0.push_back(e);
    end
    send(0, {6'b0, 1'b1, d, 1'b0}, 10);
  endtask

  task automatic wait_idle(input int which, input int limit, input string name);
    for (int k = 0; k < limit; k++) begin
      if ((which == 0 ? busy0 : busy1) == 1'b0) break;
      @(posedge clk); #1;
    end
    check(name, 32'(which == 0 ? busy0 : busy1), 0);
  endtask

  task automatic frame1(input logic [6:0] d, input bit perr, input bit s1, input bit s2);
    exp_t e;
    int   c0;
    logic p;
    p = (^d) ^ perr;
    @(posedge clk); #1;
    c0 = cyc;
    e.data = {2'b0, d};
    e.user = {~(s1 & s2), perr};
    e.lat  = exp_lat(c0, 10);
    q1.push_back(e);
    send(1, {5'b0, s2, s1, p, d, 1'b0}, 11);
    if (!s2) begin
      repeat (2 * CPB) @(posedge clk); #1;
      check("break_busy1", 32'(busy1), 1);
      rxd1 = 1'b1;
      wait_idle(1, 10, "break_release_idle1");
    end
  endtask

  task automatic wait_drain(input int which, input int limit, input string name);
    for (int k = 0; k < limit; k++) begin
      if ((which == 0 ? q0.size() : q1.size()) == 0) break;
      @(posedge clk); #1;
    end
    check(name, (which == 0 ? q0.size() : q1.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    exp_t e;

    repeat (3) @(posedge clk); #1;
    check("rst_tvalid0", 32'(tvalid0), 0);
    check("rst_tdata0", 32'(tdata0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_ovr0", 32'(ovr0), 0);
    check("rst_tvalid1", 32'(tvalid1), 0);
    check("rst_tuser1", 32'(tuser1), 0);
    rst = 1'b0;
    tready0 = 1'b1;
    tready1 = 1'b1;

    // 8N1 with tready held high: one-cycle valid per word, then idle.
    frame0(8'hA5, 1, 1);
    wait_idle(0, 2 * CPB, "a5_idle0");
    for (int i = 0; i < 8; i++) begin
      frame0(8'($urandom), 1, 1);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    wait_drain(0, 4 * CPB, "drain_rand0");

    // Four-clock glitch must not produce a word.
    @(posedge clk); #1;
    rxd0 = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("glitch_busy0", 32'(busy0), 1);
    rxd0 = 1'b1;
    wait_idle(0, 10, "glitch_idle0");
    repeat (3 * CPB) @(posedge clk); #1;
    check("valid_cycles0", vcyc0, 9);

    // 7E2: parity good, parity bad, framing error into break, clean recovery, random mix.
    frame1(7'h41, 0, 1, 1);
    frame1(7'h41, 1, 1, 1);
    frame1(7'h3C, 0, 1, 0);
    frame1(7'h5A, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      frame1(7'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    wait_drain(1, 4 * CPB, "drain1");

    // Backpressure: the second frame is dropped with one overrun pulse.
    tready0 = 1'b0;
    frame0(8'h11, 1, 1);
    frame0(8'h22, 0, 0);
    repeat (CPB) @(posedge clk); #1;
    check("overrun_count0", ocnt0, 1);
    check("held_valid0", 32'(tvalid0), 1);
    tready0 = 1'b1;
    wait_drain(0, 10, "drain_11");
    repeat (2) @(posedge clk); #1;
    check("idle_after_drain0", 32'(tvalid0), 0);

    // tready pulsed exactly in the frame-complete cycle: handshake plus reload, no overrun.
    tready0 = 1'b0;
    frame0(8'h33, 1, 1);
    @(posedge clk); #1;
    c0 = cyc;
    e.data = 9'h044;
    e.user = 2'b00;
    e.lat  = exp_lat(c0, 9);
    q0.push_back(e);
    fork
      send(0, {6'b0, 1'b1, 8'h44, 1'b0}, 10);
      begin
        repeat (3 + HALF + 9 * CPB) @(posedge clk); #1;
        tready0 = 1'b1;
        @(posedge clk); #1;
        tready0 = 1'b0;
      end
    join
    repeat (CPB) @(posedge clk); #1;
    check("overrun_after_pulse0", ocnt0, 1);
    check("held_44_valid0", 32'(tvalid0), 1);
    tready0 = 1'b1;
    wait_drain(0, 10, "drain_44");

    // Reset mid-frame discards both the held word and the partial frame.
    tready0 = 1'b0;
    frame0(8'h55, 0, 0);
    check("held_55_valid0", 32'(tvalid0), 1);
    @(posedge clk); #1;
    send(0, {7'b0, 8'h77, 1'b0}, 5);
    rst = 1'b1;
    #1;
    check("midrst_tvalid0", 32'(tvalid0), 0);
    check("midrst_tdata0", 32'(tdata0), 0);
    check("midrst_tuser0", 32'(tuser0), 0);
    check("midrst_busy0", 32'(busy0), 0);
    check("midrst_ovr0", 32'(ovr0), 0);
    rxd0 = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    tready0 = 1'b1;
    frame0(8'h99, 1, 1);
    wait_drain(0, 4 * CPB, "drain_99");

    repeat (CPB) @(posedge clk); #1;
    check("final_overrun0", ocnt0, 1);
    check("final_overrun1", ocnt1, 0);
    check("final_busy1", 32'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
